// File: rtl/mem_responder_if.sv
// Request/ready bus between the multicycle datapath (master) and its memory (slave).
interface mem_responder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req;
    logic             we;
    logic [31:0]      addr;
    logic [WIDTH-1:0] wd;
    logic             ready;
    logic [WIDTH-1:0] rd;
    logic             err;

    modport master (
        output req, we, addr, wd,
        input  ready, rd, err
    );

    modport slave (
        input  req, we, addr, wd,
        output ready, rd, err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed unified memory with programmable wait time, registered read data
// and a misaligned-access flag. Answers one request at a time: IDLE -> BUSY -> DONE.
module mem_responder #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned LATENCY    = 2
) (
    input logic             clk,
    input logic             reset,
    mem_responder_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, mis_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [WIDTH-1:0]      wd_q;
    logic [WIDTH-1:0]      rd_q;
    logic                  err_q;
    logic [WIDTH-1:0]      mem [DEPTH];

    // Access being committed this edge: live inputs when LATENCY==0, latched copy otherwise.
    logic                  commit;
    logic                  acc_we, acc_mis;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [WIDTH-1:0]      acc_wd;

    // Address bits above the word index alias onto the array.
    logic unused_addr;
    assign unused_addr = ^bus.addr[31:DEPTH_LOG2+2];

    // Next-state, wait counter and commit selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        acc_we  = we_q;
        acc_idx = idx_q;
        acc_wd  = wd_q;
        acc_mis = mis_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (LAT == 4'd0) begin
                        state_d = DONE;
                        commit  = 1'b1;
                        acc_we  = bus.we;
                        acc_idx = bus.addr[DEPTH_LOG2+1:2];
                        acc_wd  = bus.wd;
                        acc_mis = |bus.addr[1:0];
                    end else begin
                        state_d = BUSY;
                        cnt_d   = LAT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state and the request latched when it is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && bus.req) begin
                we_q  <= bus.we;
                mis_q <= |bus.addr[1:0];
                idx_q <= bus.addr[DEPTH_LOG2+1:2];
                wd_q  <= bus.wd;
            end
        end
    end

    // Memory array: not cleared by reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && commit && acc_we && !acc_mis) begin
            mem[acc_idx] <= acc_wd;
        end
    end

    // Response registers: updated only on the commit edge, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            err_q <= 1'b0;
        end else if (commit) begin
            if (acc_mis) begin
                rd_q  <= '0;
                err_q <= 1'b1;
            end else begin
                err_q <= 1'b0;
                if (!acc_we) begin
                    rd_q <= mem[acc_idx];
                end
            end
        end
    end

    assign bus.ready = (state_q == DONE);
    assign bus.rd    = rd_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with LATENCY=2, one with LATENCY=0.
// Expected responses come from a small memory model and go through a scoreboard queue.
module tb_mem_responder;
    localparam int L0 = 0;  // LATENCY=0 instance
    localparam int L2 = 1;  // LATENCY=2 instance

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_responder_if #(.WIDTH(32)) bus2 ();
    mem_responder_if #(.WIDTH(32)) bus0 ();

    mem_responder #(.WIDTH(32), .DEPTH_LOG2(6), .LATENCY(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    mem_responder #(.WIDTH(32), .DEPTH_LOG2(6), .LATENCY(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] model_mem [2][64];
    logic [31:0] model_rd [2];
    int          n_checks = 0;
    int          n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == L0) begin
            bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wd = d;
        end else begin
            bus2.req = r; bus2.we = w; bus2.addr = a; bus2.wd = d;
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == L0) ? bus0.ready : bus2.ready;
    endfunction

    function automatic logic [31:0] get_rd(input int sel);
        return (sel == L0) ? bus0.rd : bus2.rd;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == L0) ? bus0.err : bus2.err;
    endfunction

    // Call just after a rising edge with the DUT in IDLE. Returns the time ready was seen.
    task automatic access(input int sel, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input bit hold, output time t_ready);
        resp_t e;
        resp_t got;
        int    idx;
        int    cyc;
        bit    seen;
        idx = int'(a[7:2]);
        if (a[1:0] != 2'b00) begin
            e.rd  = 32'h0;
            e.err = 1'b1;
        end else if (w) begin
            model_mem[sel][idx] = d;
            e.rd  = model_rd[sel];
            e.err = 1'b0;
        end else begin
            e.rd  = model_mem[sel][idx];
            e.err = 1'b0;
        end
        model_rd[sel] = e.rd;
        sb.push_back(e);

        drive(sel, 1'b1, w, a, d);
        @(posedge clk);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            seen = get_ready(sel);
        end
        t_ready = $time;
        check("latency", 32'(cyc), (sel == L0) ? 32'd1 : 32'd3);
        got = sb.pop_front();
        check("rd", get_rd(sel), got.rd);
        check("err", {31'b0, get_err(sel)}, {31'b0, got.err});
        @(posedge clk);
        #1;
        if (!hold) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        check("ready_one_cycle", {31'b0, get_ready(sel)}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        time t, t_a, t_b, t_c;

        reset = 1'b1;
        drive(L0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(L2, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_rd[L0] = 32'h0;
        model_rd[L2] = 32'h0;

        // Idle after reset: no response, cleared outputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_ready", {31'b0, bus2.ready}, 32'h0);
            check("idle_rd", bus2.rd, 32'h0);
            check("idle_err", {31'b0, bus2.err}, 32'h0);
            check("idle_ready0", {31'b0, bus0.ready}, 32'h0);
        end
        @(posedge clk);
        #1;

        // LATENCY=2: write then read back.
        access(L2, 1'b1, 32'h8, 32'hABCD1234, 1'b0, t);
        access(L2, 1'b0, 32'h8, 32'h0, 1'b0, t);
        check("read_8", bus2.rd, 32'hABCD1234);

        // Misaligned write is flagged and leaves memory alone.
        access(L2, 1'b1, 32'hA, 32'h0200500C, 1'b0, t);
        check("mis_err", {31'b0, bus2.err}, 32'h1);
        check("mis_rd", bus2.rd, 32'h0);
        access(L2, 1'b0, 32'h8, 32'h0, 1'b0, t);
        check("read_8_after_mis", bus2.rd, 32'hABCD1234);

        // Address wrap: 0x100 aliases 0x000.
        access(L2, 1'b1, 32'h0, 32'h11111111, 1'b0, t);
        access(L2, 1'b0, 32'h100, 32'h0, 1'b0, t);
        check("wrap_rd", bus2.rd, 32'h11111111);

        // Reset during BUSY aborts a write.
        access(L2, 1'b1, 32'h4, 32'h55AA55AA, 1'b0, t);
        drive(L2, 1'b1, 1'b1, 32'h4, 32'h0200500C);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(L2, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_rd[L0] = 32'h0;
        model_rd[L2] = 32'h0;
        check("abort_rd", bus2.rd, 32'h0);
        check("abort_err", {31'b0, bus2.err}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_ready", {31'b0, bus2.ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        access(L2, 1'b0, 32'h4, 32'h0, 1'b0, t);
        check("abort_no_write", bus2.rd, 32'h55AA55AA);

        // LATENCY=0: fill three words, then back-to-back reads with req held.
        access(L0, 1'b1, 32'h10, 32'hCAFE0001, 1'b0, t);
        access(L0, 1'b1, 32'h14, 32'hCAFE0002, 1'b0, t);
        access(L0, 1'b1, 32'h18, 32'hCAFE0003, 1'b0, t);
        access(L0, 1'b0, 32'h14, 32'h0, 1'b1, t_a);
        access(L0, 1'b0, 32'h18, 32'h0, 1'b1, t_b);
        access(L0, 1'b0, 32'h10, 32'h0, 1'b0, t_c);
        check("b2b_last_rd", bus0.rd, 32'hCAFE0001);
        check("b2b_period_1", 32'(t_b - t_a), 32'd20);
        check("b2b_period_2", 32'(t_c - t_b), 32'd20);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
